maze_round_ctrl: RTL and testbench



---
 rtl/maze_round_ctrl.sv | 159 +++++++++++++++
 tb/tb_maze_round_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/maze_round_ctrl.sv
// Maze round controller: debounces the start/level buttons, picks the maze size, drives the
// timer's load/run line and latches the round result and final BCD time.
module maze_round_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_LOAD_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_start,
    input  logic        btn_level,
    input  logic        goal,
    input  logic [15:0] time_bcd,
    output logic [4:0]  size,
    output logic        start,
    output logic [1:0]  state,
    output logic        win,
    output logic        fail,
    output logic [15:0] final_time
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LoadW = $clog2(MIN_LOAD_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWin  = 2'd2,
        StFail = 2'd3
    } state_e;

    // Index 0 = start button, index 1 = level button.
    logic [1:0]      btn_raw;
    logic [1:0]      meta_q, sync_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      press_q;
    logic [CntW-1:0] db_cnt_q [2];
    logic [CntW-1:0] db_cnt_d [2];

    assign btn_raw = {btn_level, btn_start};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q   <= '0;
            sync_q   <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            db_cnt_q <= '{default: '0};
        end else begin
            meta_q   <= btn_raw;
            sync_q   <= meta_q;
            deb_q    <= deb_d;
            press_q  <= deb_d & ~deb_q;
            db_cnt_q <= db_cnt_d;
        end
    end

    logic start_press, level_press;
    assign start_press = press_q[0];
    assign level_press = press_q[1];

    state_e           state_q, state_d;
    logic [4:0]       size_q, size_d, size_next;
    logic [15:0]      final_time_q, final_time_d;
    logic [LoadW-1:0] load_cnt_q, load_cnt_d;
    logic             start_q, start_d, win_q, win_d, fail_q, fail_d;
    logic             armed, timeout;

    assign armed     = (load_cnt_q == LoadW'(MIN_LOAD_CYCLES));
    assign timeout   = (time_bcd == 16'h0000) || (time_bcd == 16'h9999);
    assign size_next = (size_q == 5'd19) ? 5'd5 : size_q + 5'd2;

    // Held at zero outside IDLE, so it restarts from zero on every entry to IDLE.
    always_comb begin
        load_cnt_d = '0;
        if (state_q == StIdle) begin
            load_cnt_d = armed ? load_cnt_q : load_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            size_q       <= 5'd5;
            final_time_q <= 16'h0000;
            load_cnt_q   <= '0;
            start_q      <= 1'b0;
            win_q        <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            final_time_q <= final_time_d;
            load_cnt_q   <= load_cnt_d;
            start_q      <= start_d;
            win_q        <= win_d;
            fail_q       <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        final_time_d = final_time_q;
        case (state_q)
            StIdle: begin
                if (level_press) size_d = size_next;
                if (start_press && armed) state_d = StRun;
            end
            StRun: begin
                if (goal) begin
                    state_d      = StWin;
                    final_time_d = time_bcd;
                end else if (timeout) begin
                    state_d      = StFail;
                    final_time_d = 16'h0000;
                end
            end
            StWin: begin
                if (start_press) begin
                    state_d = StIdle;
                    size_d  = size_next;
                end
            end
            StFail: begin
                if (start_press) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside state_q.
    always_comb begin
        start_d = (state_d == StRun);
        win_d   = (state_d == StWin);
        fail_d  = (state_d == StFail);
    end

    assign state      = state_q;
    assign size       = size_q;
    assign start      = start_q;
    assign win        = win_q;
    assign fail       = fail_q;
    assign final_time = final_time_q;

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Directed bench for maze_round_ctrl with short debounce and load intervals.
module tb_maze_round_ctrl;

    logic        clk;
    logic        rstn;
    logic        btn_start;
    logic        btn_level;
    logic        goal;
    logic [15:0] time_bcd;
    logic [4:0]  size;
    logic        start;
    logic [1:0]  state;
    logic        win;
    logic        fail;
    logic [15:0] final_time;

    int checks;
    int failures;

    maze_round_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .MIN_LOAD_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_start  (btn_start),
        .btn_level  (btn_level),
        .goal       (goal),
        .time_bcd   (time_bcd),
        .size       (size),
        .start      (start),
        .state      (state),
        .win        (win),
        .fail       (fail),
        .final_time (final_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_state, input logic [4:0] e_size,
                              input logic e_start, input logic [15:0] e_final);
        check_eq({tag, ".state"}, 32'(state), 32'(e_state));
        check_eq({tag, ".size"}, 32'(size), 32'(e_size));
        check_eq({tag, ".start"}, 32'(start), 32'(e_start));
        check_eq({tag, ".win"}, 32'(win), 32'(e_state == 2'd2));
        check_eq({tag, ".fail"}, 32'(fail), 32'(e_state == 2'd3));
        check_eq({tag, ".final"}, 32'(final_time), 32'(e_final));
    endtask

    // Clean press: 8 cycles high, 8 cycles low; ends just after a posedge.
    task automatic press(input bit is_level);
        @(posedge clk); #1;
        if (is_level) btn_level = 1'b1; else btn_start = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        if (is_level) btn_level = 1'b0; else btn_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_wait();
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] exp_size;
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        btn_start = 1'b0;
        btn_level = 1'b0;
        goal      = 1'b0;
        time_bcd  = 16'h0500;
        repeat (3) @(negedge clk);
        check_outs("reset", 2'd0, 5'd5, 1'b0, 16'h0000);
        rstn = 1'b1;

        // 1: level presses cycle the size through all odd values and wrap.
        exp_size = 5'd5;
        for (int i = 0; i < 8; i++) begin
            press(1'b1);
            exp_size = (exp_size == 5'd19) ? 5'd5 : exp_size + 5'd2;
            check_eq($sformatf("lvl%0d.size", i), 32'(size), 32'(exp_size));
            check_eq($sformatf("lvl%0d.start", i), 32'(start), 32'd0);
        end

        // 2: bouncing start then a clean hold gives exactly one pulse at a known cycle.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 btn_start = 1'b1;
            @(posedge clk); @(posedge clk); #1 btn_start = 1'b0;
            @(posedge clk);
        end
        @(posedge clk); #1 btn_start = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("bounce.pre_state", 32'(state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outs("bounce.run", 2'd1, 5'd5, 1'b1, 16'h0000);
        repeat (2) @(posedge clk);
        #1 btn_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("run.start_ignored", 32'(state), 32'd1);

        // 4: goal wins and latches the live time; start returns to IDLE one size up.
        time_bcd = 16'h0123;
        @(posedge clk); #1 goal = 1'b1;
        @(posedge clk); #1 goal = 1'b0;
        @(negedge clk);
        check_outs("win", 2'd2, 5'd5, 1'b0, 16'h0123);
        time_bcd = 16'h0500;
        press(1'b1);
        check_eq("win.level_ignored", 32'(size), 32'd5);
        press(1'b0);
        check_outs("win.ack", 2'd0, 5'd7, 1'b0, 16'h0123);

        // 5: underflow wrap and direct zero both fail; size frozen during RUN.
        idle_wait();
        press(1'b0);
        check_eq("run2.state", 32'(state), 32'd1);
        press(1'b1);
        check_eq("run2.size_frozen", 32'(size), 32'd7);
        time_bcd = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("run2.one_left", 32'(state), 32'd1);
        time_bcd = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        check_outs("fail_wrap", 2'd3, 5'd7, 1'b0, 16'h0000);
        time_bcd = 16'h0500;
        press(1'b0);
        check_outs("fail_wrap.ack", 2'd0, 5'd7, 1'b0, 16'h0000);
        idle_wait();
        press(1'b0);
        check_eq("run3.state", 32'(state), 32'd1);
        time_bcd = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        check_outs("fail_zero", 2'd3, 5'd7, 1'b0, 16'h0000);
        time_bcd = 16'h0500;
        press(1'b0);
        check_outs("fail_zero.ack", 2'd0, 5'd7, 1'b0, 16'h0000);

        // 6: goal beats a simultaneous timeout.
        idle_wait();
        press(1'b0);
        check_eq("run4.state", 32'(state), 32'd1);
        @(posedge clk); #1;
        goal     = 1'b1;
        time_bcd = 16'h9999;
        @(posedge clk); #1;
        goal     = 1'b0;
        time_bcd = 16'h0500;
        @(negedge clk);
        check_outs("win_prio", 2'd2, 5'd7, 1'b0, 16'h9999);
        press(1'b0);
        check_outs("win_prio.ack", 2'd0, 5'd9, 1'b0, 16'h9999);

        // 6: asynchronous reset mid-round, seen before the next edge.
        idle_wait();
        press(1'b0);
        check_eq("run5.state", 32'(state), 32'd1);
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        check_outs("async_rst", 2'd0, 5'd5, 1'b0, 16'h0000);

        // 3: a press completing before the load interval is ignored, a later one is taken.
        btn_start = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("early.state", 32'(state), 32'd0);
        check_eq("early.start", 32'(start), 32'd0);
        btn_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("early.still_idle", 32'(state), 32'd0);
        press(1'b0);
        check_outs("late.run", 2'd1, 5'd5, 1'b1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
